// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
//   Hazard / stall / flush controller for a 5-stage in-order pipeline.
//   Handles load-use stalls, taken-branch flushes in MEM, and data-memory
//   wait states with a timeout that latches a permanent FAULT until reset.
//
// Parameters
//   TIMEOUT      max wait cycles for dmem_ack before FAULT (1..255)
//
// Ports
//   clk, reset                      clock, synchronous active-low reset
//   id_rs1/id_rs2, id_use_rs1/2     ID-stage source registers and use flags
//   ex_memread, ex_rd               EX-stage load flag and destination
//   mem_br_taken                    branch in MEM resolved taken
//   dmem_req, dmem_ack              data-memory handshake from MEM
//   *_en, *_flush                   PC / pipeline-register load and bubble
//   pc_sel_br                       PC takes the branch target
//   state                           00 RUN, 01 MEM_WAIT, 10 FAULT
//   mem_err                         sticky timeout fault
//   stall_cnt, flush_cnt            saturating event counters
// ----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        mem_br_taken,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        pc_sel_br,
    output logic [1:0]  state,
    output logic        mem_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [1:0] S_RUN   = 2'b00;
    localparam logic [1:0] S_WAIT  = 2'b01;
    localparam logic [1:0] S_FAULT = 2'b10;

    localparam logic [7:0] TO_LIM = TIMEOUT[7:0];

    logic [7:0] wait_cnt;
    logic       hazard;
    logic       mem_stall;

    // Register 31 is excluded: it never creates a load-use dependency.
    always_comb begin
        hazard = ex_memread && (ex_rd != 5'd31) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // Freeze the front of the pipe while memory is outstanding. Once in
    // MEM_WAIT only the ack matters; the cycle that acks runs normally.
    always_comb begin
        mem_stall = ((state == S_RUN)  && dmem_req && !dmem_ack) ||
                    ((state == S_WAIT) && !dmem_ack);
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        pc_sel_br    = 1'b0;
        if (!reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (state == S_FAULT) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (mem_stall) begin
            // MEM_WB keeps clocking, but takes a bubble so WB does not
            // retire the stalled MEM instruction repeatedly.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (mem_br_taken) begin
            // Squash the three younger instructions; overrides load-use.
            pc_sel_br    = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_RUN;
            wait_cnt  <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            case (state)
                S_RUN: begin
                    if (dmem_req && !dmem_ack) begin
                        state    <= S_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        state    <= S_RUN;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == TO_LIM) begin
                        state   <= S_FAULT;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_RUN;
            endcase
            if ((state != S_FAULT) && !pc_en && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (pc_sel_br && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed scoreboard bench for pipeline_ctrl (TIMEOUT=4). The stimulus
//   process drives one input vector per cycle and queues the hand-computed
//   outputs for that cycle; the monitor pops and compares on the falling edge.
//   Control vector order: {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,
//   if_id_flush,id_ex_flush,ex_mem_flush,mem_wb_flush,pc_sel_br}.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam logic [9:0] C_RUN = 10'b11111_0000_0;
    localparam logic [9:0] C_LU  = 10'b00111_0100_0;
    localparam logic [9:0] C_BR  = 10'b11111_1110_1;
    localparam logic [9:0] C_MW  = 10'b00001_0001_0;
    localparam logic [9:0] C_FLT = 10'b00000_0000_0;
    localparam logic [9:0] C_RST = 10'b00000_1111_0;

    typedef struct {
        string       name;
        logic [9:0]  ctrl;
        logic [1:0]  st;
        logic        err;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_memread;
    logic        mem_br_taken, dmem_req, dmem_ack;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        pc_sel_br, mem_err;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pipeline_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_br_taken(mem_br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .pc_sel_br(pc_sel_br), .state(state), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // inputs: rs1 rs2 use1 use2 memread rd br req ack
    task automatic set_in(input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2, input logic mr,
                          input logic [4:0] rd, input logic br,
                          input logic rq, input logic ak);
        id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_memread = mr; ex_rd = rd; mem_br_taken = br;
        dmem_req = rq; dmem_ack = ak;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue what this cycle should show, then advance one cycle.
    task automatic chk(input string nm, input logic [9:0] c, input logic [1:0] s,
                       input logic e, input logic [15:0] sc, input logic [15:0] fc);
        exp_t x;
        x.name = nm; x.ctrl = c; x.st = s; x.err = e; x.sc = sc; x.fc = fc;
        q.push_back(x);
        @(posedge clk); #1;
    endtask

    // Monitor: one output sample per cycle, compared away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t x;
                logic [9:0] act;
                x = q.pop_front();
                act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_sel_br};
                n_cmp++;
                if (act !== x.ctrl || state !== x.st || mem_err !== x.err ||
                    stall_cnt !== x.sc || flush_cnt !== x.fc) begin
                    n_err++;
                    $display("FAIL %s: got ctrl=%b st=%b err=%b stall=%0d flush=%0d, want ctrl=%b st=%b err=%b stall=%0d flush=%0d",
                             x.name, act, state, mem_err, stall_cnt, flush_cnt,
                             x.ctrl, x.st, x.err, x.sc, x.fc);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        idle();
        @(posedge clk); #1;
        chk("reset_hold", C_RST, 2'b00, 1'b0, 16'd0, 16'd0);
        reset = 1'b1;

        chk("idle", C_RUN, 2'b00, 1'b0, 16'd0, 16'd0);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("lu_rs1", C_LU, 2'b00, 1'b0, 16'd0, 16'd0);
        idle();
        chk("lu_after", C_RUN, 2'b00, 1'b0, 16'd1, 16'd0);
        set_in(5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("lu_rs2", C_LU, 2'b00, 1'b0, 16'd1, 16'd0);
        set_in(5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("lu_nouse", C_RUN, 2'b00, 1'b0, 16'd2, 16'd0);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("no_load", C_RUN, 2'b00, 1'b0, 16'd2, 16'd0);
        set_in(5'd31, 5'd0, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
        chk("r31", C_RUN, 2'b00, 1'b0, 16'd2, 16'd0);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("br_lu", C_BR, 2'b00, 1'b0, 16'd2, 16'd0);
        idle();
        chk("br_after", C_RUN, 2'b00, 1'b0, 16'd2, 16'd1);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("req_ack", C_RUN, 2'b00, 1'b0, 16'd2, 16'd1);

        // ack low three cycles, then ack with a branch present
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mw0", C_MW, 2'b00, 1'b0, 16'd2, 16'd1);
        chk("mw1", C_MW, 2'b01, 1'b0, 16'd3, 16'd1);
        chk("mw2", C_MW, 2'b01, 1'b0, 16'd4, 16'd1);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        chk("mw_ack_br", C_BR, 2'b01, 1'b0, 16'd5, 16'd1);
        idle();
        chk("mw_done", C_RUN, 2'b00, 1'b0, 16'd5, 16'd2);

        // memory wait beats branch and load-use, then times out
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        chk("mw_prio", C_MW, 2'b00, 1'b0, 16'd5, 16'd2);
        chk("to1", C_MW, 2'b01, 1'b0, 16'd6, 16'd2);
        chk("to2", C_MW, 2'b01, 1'b0, 16'd7, 16'd2);
        chk("to3", C_MW, 2'b01, 1'b0, 16'd8, 16'd2);
        chk("to4", C_MW, 2'b01, 1'b0, 16'd9, 16'd2);
        chk("fault", C_FLT, 2'b10, 1'b1, 16'd10, 16'd2);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        chk("fault_ign", C_FLT, 2'b10, 1'b1, 16'd10, 16'd2);
        idle();
        reset = 1'b0;
        chk("fault_rst", C_RST, 2'b10, 1'b1, 16'd10, 16'd2);
        reset = 1'b1;
        chk("post_fault", C_RUN, 2'b00, 1'b0, 16'd0, 16'd0);

        // reset in the middle of a memory wait
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mwr0", C_MW, 2'b00, 1'b0, 16'd0, 16'd0);
        reset = 1'b0;
        chk("mwr_rst", C_RST, 2'b01, 1'b0, 16'd1, 16'd0);
        reset = 1'b1;
        idle();
        chk("mwr_post", C_RUN, 2'b00, 1'b0, 16'd0, 16'd0);

        // long load-use hold: stall counter saturates
        set_in(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        chk("sat", C_LU, 2'b00, 1'b0, 16'hFFFF, 16'd0);
        idle();
        chk("sat_idle", C_RUN, 2'b00, 1'b0, 16'hFFFF, 16'd0);

        @(negedge clk); #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
